// File: rtl/ad9231_spi_reg_reader.sv
// AD9231 3-wire SPI single-byte read-back master: 16-bit read instruction, SDIO turnaround, 8 data bits in.
// Optional expected-value compare (rd_exp / rd_mismatch) is built only when AD9231_RD_VERIFY_EN is defined.
module ad9231_spi_reg_reader #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_req,
   input  logic [12:0] rd_addr,
   output logic        rd_busy,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdio_o,
   output logic        sdio_oe,
   input  logic        sdio_i
`ifdef AD9231_RD_VERIFY_EN
   ,
   input  logic [7:0]  rd_exp,
   output logic        rd_mismatch
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_INSTR = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [4:0]  bit_cnt;
   logic [14:0] instr_sr;
   logic [7:0]  rx_sr;
`ifdef AD9231_RD_VERIFY_EN
   logic [7:0]  exp_r;
`endif

   // instr_sr holds instruction bits 14:0; bit 15 (read flag) goes straight to sdio_o at acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         instr_sr <= '0;
         rx_sr    <= '0;
         cs_n     <= 1'b1;
         sclk     <= 1'b0;
         sdio_o   <= 1'b0;
         sdio_oe  <= 1'b0;
         rd_busy  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
`ifdef AD9231_RD_VERIFY_EN
         exp_r       <= '0;
         rd_mismatch <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rd_req) begin
                  state    <= S_SETUP;
                  cnt      <= '0;
                  bit_cnt  <= '0;
                  instr_sr <= {2'b00, rd_addr};
                  cs_n     <= 1'b0;
                  rd_busy  <= 1'b1;
                  sdio_oe  <= 1'b1;
                  sdio_o   <= 1'b1;
`ifdef AD9231_RD_VERIFY_EN
                  exp_r    <= rd_exp;
`endif
               end
            end

            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  state <= S_INSTR;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_INSTR, S_DATA: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                     if (state == S_DATA) rx_sr <= {rx_sr[6:0], sdio_i};
                  end else begin
                     sclk <= 1'b0;
                     if (state == S_INSTR) begin
                        // Falling edge after the 16th rise releases SDIO to the ADC.
                        if (bit_cnt == 5'd15) begin
                           bit_cnt <= '0;
                           state   <= S_DATA;
                           sdio_oe <= 1'b0;
                           sdio_o  <= 1'b0;
                        end else begin
                           bit_cnt  <= bit_cnt + 5'd1;
                           sdio_o   <= instr_sr[14];
                           instr_sr <= {instr_sr[13:0], 1'b0};
                        end
                     end else begin
                        if (bit_cnt == 5'd7) begin
                           bit_cnt <= '0;
                           state   <= S_HOLD;
                        end else begin
                           bit_cnt <= bit_cnt + 5'd1;
                        end
                     end
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt      <= '0;
                  state    <= S_GAP;
                  cs_n     <= 1'b1;
                  rd_valid <= 1'b1;
                  rd_data  <= rx_sr;
`ifdef AD9231_RD_VERIFY_EN
                  rd_mismatch <= (rx_sr != exp_r);
`endif
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            S_GAP: begin
               // Keeps CS high for at least CS_HOLD cycles before the next request can be taken.
               if (cnt == HOLD_LAST) begin
                  cnt     <= '0;
                  state   <= S_IDLE;
                  rd_busy <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
